// File: rtl/bft_pkg.sv
// bft_pkg: shared BFT packet geometry and default sizing for the leaf input-port cluster.
package bft_pkg;
  localparam int PACKET_BITS  = 97;
  localparam int NUM_IN_PORTS = 7;
  localparam int CNT_BITS     = 32;
  localparam int PKT_VALID_BIT = 96;
  localparam int PKT_ADDR_LSB  = 64;
  localparam int PKT_ADDR_BITS = 32;
  localparam int PKT_DATA_LSB  = 0;
  localparam int PKT_DATA_BITS = 64;
  typedef logic [PACKET_BITS-1:0] packet_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the slot after ptr.
module rr_arbiter #(
  parameter int N  = 7,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int p;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p = 0;
    // walk farthest-first so the nearest requester after ptr overwrites the result last
    for (int k = N; k >= 1; k--) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (req[p]) begin
        gnt = '0;
        gnt[p] = 1'b1;
        idx = IW'(p);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/freespace_update_arbiter.sv
// freespace_update_arbiter: holds one credit packet per port and serialises them round-robin onto one stream.
// Define ARB_STATS_EN to build the per-port overwrite/grant counters; otherwise both read as zero.
module freespace_update_arbiter #(
  parameter int PACKET_BITS  = bft_pkg::PACKET_BITS,
  parameter int NUM_IN_PORTS = bft_pkg::NUM_IN_PORTS,
  parameter int CNT_BITS     = bft_pkg::CNT_BITS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_IN_PORTS-1:0]          freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports,
  output logic [PACKET_BITS-1:0]           stream_out,
  output logic                             stream_out_vld,
  input  logic                             stream_out_rdy,
  output logic [NUM_IN_PORTS-1:0]          pending,
  output logic [CNT_BITS*NUM_IN_PORTS-1:0] overwrite_cnt,
  output logic [CNT_BITS*NUM_IN_PORTS-1:0] grant_cnt
);
  localparam int IW = $clog2(NUM_IN_PORTS);
  logic [NUM_IN_PORTS-1:0][PACKET_BITS-1:0] slot_q, slot_d;
  logic [NUM_IN_PORTS-1:0] pending_q, pending_d, gnt;
  logic [PACKET_BITS-1:0] stream_out_q, stream_out_d;
  logic stream_out_vld_q, stream_out_vld_d, load_ok, any_req, grant;
  logic [IW-1:0] ptr_q, ptr_d, gidx;
  rr_arbiter #(.N(NUM_IN_PORTS), .IW(IW)) u_rr (
    .req(pending_q),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(gidx),
    .any(any_req)
  );
  always_comb begin
    load_ok = !stream_out_vld_q || stream_out_rdy;
    grant = load_ok && any_req;
    slot_d = slot_q;
    for (int i = 0; i < NUM_IN_PORTS; i++)
      if (freespace_update[i]) slot_d[i] = packet_from_input_ports[PACKET_BITS*i +: PACKET_BITS];
    // a fresh capture on the granted port keeps it pending: the old packet leaves, the new one waits
    pending_d = (pending_q & ~(grant ? gnt : '0)) | freespace_update;
    stream_out_d = grant ? slot_q[gidx] : stream_out_q;
    stream_out_vld_d = grant || (stream_out_vld_q && !load_ok);
    ptr_d = grant ? gidx : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      pending_q <= '0;
      stream_out_q <= '0;
      stream_out_vld_q <= 1'b0;
      ptr_q <= IW'(NUM_IN_PORTS-1);
    end else begin
      slot_q <= slot_d;
      pending_q <= pending_d;
      stream_out_q <= stream_out_d;
      stream_out_vld_q <= stream_out_vld_d;
      ptr_q <= ptr_d;
    end
  end
  assign stream_out = stream_out_q;
  assign stream_out_vld = stream_out_vld_q;
  assign pending = pending_q;
`ifdef ARB_STATS_EN
  logic [NUM_IN_PORTS-1:0][CNT_BITS-1:0] overwrite_cnt_q, overwrite_cnt_d, grant_cnt_q, grant_cnt_d;
  always_comb begin
    overwrite_cnt_d = overwrite_cnt_q;
    grant_cnt_d = grant_cnt_q;
    // only a pulse that actually discards an unsent packet counts as an overwrite
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      overwrite_cnt_d[i] = overwrite_cnt_q[i] + CNT_BITS'(freespace_update[i] && pending_q[i] && !(grant && gnt[i]));
      grant_cnt_d[i] = grant_cnt_q[i] + CNT_BITS'(grant && gnt[i]);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overwrite_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      overwrite_cnt_q <= overwrite_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end
  assign overwrite_cnt = overwrite_cnt_q;
  assign grant_cnt = grant_cnt_q;
`else
  assign overwrite_cnt = '0;
  assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_freespace_update_arbiter.sv
// tb_freespace_update_arbiter: table-driven plus hand-written sequences, with a scoreboard of expected output packets.
module tb_freespace_update_arbiter;
  localparam int P = 97;
  localparam int N = 7;
  localparam int C = 32;
`ifdef ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [N-1:0] freespace_update = '0;
  logic [P*N-1:0] packet_from_input_ports = '0;
  logic [P-1:0] stream_out;
  logic stream_out_vld;
  logic stream_out_rdy = 1'b0;
  logic [N-1:0] pending;
  logic [C*N-1:0] overwrite_cnt, grant_cnt;
  int checks = 0;
  int errors = 0;
  logic [P-1:0] exp_q[$];
  typedef struct {
    logic [N-1:0] mask;
    int n;
    int ord[N];
  } vec_t;
  vec_t tbl[6];

  freespace_update_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .freespace_update(freespace_update),
    .packet_from_input_ports(packet_from_input_ports),
    .stream_out(stream_out),
    .stream_out_vld(stream_out_vld),
    .stream_out_rdy(stream_out_rdy),
    .pending(pending),
    .overwrite_cnt(overwrite_cnt),
    .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] mk(input int port, input int tag);
    return {1'b1, 8'(tag), 8'(port), 16'hBEEF, 64'(tag * 7919 + port * 104729)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] mask, input int tag);
    for (int i = 0; i < N; i++) packet_from_input_ports[P*i +: P] = mk(i, tag);
    freespace_update = mask;
    cyc();
    freespace_update = '0;
  endtask

  always @(negedge clk) begin
    if (reset_n && stream_out_vld && stream_out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer got %h exp none", stream_out);
      end else begin
        chk("scoreboard", stream_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{7'h7F, 7, '{0, 1, 2, 3, 4, 5, 6}};
    tbl[1] = '{7'h24, 2, '{2, 5, 0, 0, 0, 0, 0}};
    tbl[2] = '{7'h4A, 3, '{6, 1, 3, 0, 0, 0, 0}};
    tbl[3] = '{7'h19, 3, '{4, 0, 3, 0, 0, 0, 0}};
    tbl[4] = '{7'h04, 1, '{2, 0, 0, 0, 0, 0, 0}};
    tbl[5] = '{7'h47, 4, '{6, 0, 1, 2, 0, 0, 0}};
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_vld", stream_out_vld, 0);
    chk("rst_out", stream_out, 0);
    chk("rst_ovw", overwrite_cnt, 0);
    chk("rst_gcnt", grant_cnt, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    stream_out_rdy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < tbl[r].n; k++) exp_q.push_back(mk(tbl[r].ord[k], 16 + r));
      pulse(tbl[r].mask, 16 + r);
      chk("tbl_pending", pending, tbl[r].mask);
      chk("tbl_idle", stream_out_vld, 0);
      for (int k = 0; k < tbl[r].n; k++) begin
        cyc();
        chk("tbl_nogap_vld", stream_out_vld, 1);
      end
      cyc();
      chk("tbl_drained_vld", stream_out_vld, 0);
      chk("tbl_drained_pend", pending, 0);
      if (r == 0)
        for (int i = 0; i < N; i++) chk("grant_cnt_all", grant_cnt[C*i +: C], STATS);
    end
    // single pulse, one-cycle latency
    exp_q.push_back(mk(3, 40));
    pulse(7'h08, 40);
    chk("lat_pending", pending, 7'h08);
    chk("lat_vld0", stream_out_vld, 0);
    cyc();
    chk("lat_vld1", stream_out_vld, 1);
    chk("lat_out", stream_out, mk(3, 40));
    chk("lat_pend0", pending, 0);
    cyc();
    chk("lat_done", stream_out_vld, 0);
    // backpressure
    stream_out_rdy = 1'b0;
    exp_q.push_back(mk(2, 41));
    pulse(7'h04, 41);
    cyc();
    chk("bp_vld", stream_out_vld, 1);
    pulse(7'h20, 41);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_out", stream_out, mk(2, 41));
      chk("bp_hold_vld", stream_out_vld, 1);
      cyc();
    end
    chk("bp_queued", pending, 7'h20);
    exp_q.push_back(mk(5, 41));
    stream_out_rdy = 1'b1;
    cyc();
    chk("bp_next_out", stream_out, mk(5, 41));
    chk("bp_next_vld", stream_out_vld, 1);
    cyc();
    chk("bp_done", stream_out_vld, 0);
    // overwrite while output is stalled
    stream_out_rdy = 1'b0;
    exp_q.push_back(mk(6, 42));
    pulse(7'h40, 42);
    cyc();
    pulse(7'h02, 43);
    pulse(7'h02, 44);
    chk("ovw_pending", pending, 7'h42 & 7'h02);
    chk("ovw_cnt1", overwrite_cnt[C*1 +: C], STATS);
    exp_q.push_back(mk(1, 44));
    stream_out_rdy = 1'b1;
    cyc();
    chk("ovw_out_b", stream_out, mk(1, 44));
    cyc();
    chk("ovw_done", stream_out_vld, 0);
    // grant and new capture on the same port, same edge
    exp_q.push_back(mk(4, 45));
    exp_q.push_back(mk(4, 46));
    pulse(7'h10, 45);
    pulse(7'h10, 46);
    chk("same_out_c", stream_out, mk(4, 45));
    chk("same_pend", pending, 7'h10);
    cyc();
    chk("same_out_d", stream_out, mk(4, 46));
    chk("same_pend0", pending, 0);
    cyc();
    chk("same_done", stream_out_vld, 0);
    // async reset mid-stream
    stream_out_rdy = 1'b0;
    pulse(7'h01, 47);
    cyc();
    pulse(7'h0E, 47);
    chk("pre_rst_pend", pending, 7'h0E);
    chk("pre_rst_vld", stream_out_vld, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_pend", pending, 0);
    chk("arst_vld", stream_out_vld, 0);
    chk("arst_out", stream_out, 0);
    exp_q.delete();
    cyc();
    cyc();
    reset_n = 1'b1;
    stream_out_rdy = 1'b1;
    cyc();
    exp_q.push_back(mk(0, 48));
    exp_q.push_back(mk(4, 48));
    exp_q.push_back(mk(6, 48));
    pulse(7'h51, 48);
    chk("post_rst_pend", pending, 7'h51);
    cyc();
    chk("post_rst_first", stream_out, mk(0, 48));
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    cyc();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", stream_out_vld, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
